// File: rtl/clock_pkg.sv
// Shared types and default parameters for the clock configuration loader.
package clock_pkg;

  // Load sequence phases: preamble, serial shift, postamble.
  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StShift,
    StPost
  } clk_cfg_state_e;

  localparam int unsigned DivWDefault       = 32;
  localparam int unsigned PreCyclesDefault  = 2;
  localparam int unsigned PostCyclesDefault = 2;
  // 1 Hz slow clock from a 12 MHz source.
  localparam int unsigned DefaultDivDefault = 5_999_999;

endpackage

// File: rtl/clock_cfg_shifter.sv
// Parallel-load, LSB-first shift register with a bit index counter.
module clock_cfg_shifter #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             bit_o,
  output logic             last_o
);

  localparam int unsigned CntW = $clog2(DIV_W);

  logic [DIV_W-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;

  // Load restarts the index at 0; the counter saturates on the last bit instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_val_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q <= sr_q >> 1;
      if (!last_o) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign bit_o  = sr_q[0];
  assign last_o = (cnt_q == CntW'(DIV_W - 1));

endmodule

// File: rtl/clock_config_loader.sv
// Serialises divider values into a clock divider: preamble, LSB-first shift, postamble.
// Holds one active value and a single pending slot; loads DEFAULT_DIV after reset.
module clock_config_loader
  import clock_pkg::*;
#(
  parameter int unsigned DIV_W       = DivWDefault,
  parameter int unsigned PRE_CYCLES  = PreCyclesDefault,
  parameter int unsigned POST_CYCLES = PostCyclesDefault,
  parameter int unsigned DEFAULT_DIV = DefaultDivDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic [DIV_W-1:0] req_div_i,
  output logic             req_ready_o,
  output logic             clock_change_mode_o,
  output logic             clock_max_count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [DIV_W-1:0] cur_div_o
);

  localparam int unsigned PhMax = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax) + 1;

  clk_cfg_state_e   state_q;
  logic [DIV_W-1:0] active_q;
  logic [DIV_W-1:0] pend_q;
  logic [DIV_W-1:0] cur_div_q;
  logic             pend_full_q;
  logic             boot_q;
  logic             mode_q;
  logic [PhW-1:0]   ph_q;

  logic accept;
  logic pre_last;
  logic post_last;
  logic shift_bit;
  logic shift_last;

  // boot_q holds ready low until the automatic default load has been kicked off.
  assign req_ready_o = !pend_full_q && !boot_q;
  assign accept      = req_valid_i && req_ready_o;
  assign pre_last    = (state_q == StPre)  && (ph_q == PhW'(PRE_CYCLES - 1));
  assign post_last   = (state_q == StPost) && (ph_q == PhW'(POST_CYCLES - 1));

  clock_cfg_shifter #(
    .DIV_W (DIV_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pre_last),
    .shift_i    (state_q == StShift),
    .load_val_i (active_q),
    .bit_o      (shift_bit),
    .last_o     (shift_last)
  );

  // Sequencer FSM plus pending slot; new requests never touch the value in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      active_q    <= '0;
      pend_q      <= '0;
      cur_div_q   <= '0;
      pend_full_q <= 1'b0;
      boot_q      <= 1'b1;
      mode_q      <= 1'b0;
      ph_q        <= '0;
    end else begin
      // Fill and drain of the slot are mutually exclusive: fill needs it empty.
      if (accept && (state_q != StIdle)) begin
        pend_q      <= req_div_i;
        pend_full_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (boot_q) begin
            active_q <= DIV_W'(DEFAULT_DIV);
            boot_q   <= 1'b0;
            state_q  <= StPre;
            ph_q     <= '0;
            mode_q   <= 1'b1;
          end else if (pend_full_q) begin
            // Request that landed on the last postamble cycle of an empty slot.
            active_q    <= pend_q;
            pend_full_q <= 1'b0;
            state_q     <= StPre;
            ph_q        <= '0;
            mode_q      <= 1'b1;
          end else if (accept) begin
            active_q <= req_div_i;
            state_q  <= StPre;
            ph_q     <= '0;
            mode_q   <= 1'b1;
          end
        end
        StPre: begin
          if (pre_last) begin
            state_q <= StShift;
          end else begin
            ph_q <= ph_q + PhW'(1);
          end
        end
        StShift: begin
          if (shift_last) begin
            state_q   <= StPost;
            ph_q      <= '0;
            mode_q    <= 1'b0;
            cur_div_q <= active_q;
          end
        end
        StPost: begin
          if (post_last) begin
            if (pend_full_q) begin
              active_q    <= pend_q;
              pend_full_q <= 1'b0;
              state_q     <= StPre;
              ph_q        <= '0;
              mode_q      <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            ph_q <= ph_q + PhW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clock_change_mode_o = mode_q;
  assign clock_max_count_o   = (state_q == StShift) && shift_bit;
  assign busy_o              = (state_q != StIdle);
  assign done_o              = post_last;
  assign cur_div_o           = cur_div_q;

endmodule

// File: tb/tb_clock_config_loader.sv
// Directed bench for clock_config_loader with a scoreboard of expected divider values.
module tb_clock_config_loader;

  localparam int unsigned W    = 32;
  localparam int unsigned PRE  = 2;
  localparam int unsigned POST = 2;
  localparam logic [W-1:0] DEF = 32'd5_999_999;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_i;
  logic [W-1:0] req_div_i;
  logic         ready;
  logic         mode;
  logic         ser;
  logic         busy;
  logic         done;
  logic [W-1:0] cur_div;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];

  clock_config_loader dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid_i),
    .req_div_i           (req_div_i),
    .req_ready_o         (ready),
    .clock_change_mode_o (mode),
    .clock_max_count_o   (ser),
    .busy_o              (busy),
    .done_o              (done),
    .cur_div_o           (cur_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until done_o, starting from n0; bounded so a stuck DUT still reports.
  task automatic wait_done(input string tag, input int n0, input int exp_n);
    int n = n0;
    do begin
      tick();
      n++;
    end while (!done && n < 200);
    chk(tag, n, exp_n);
  endtask

  task automatic send(input string tag, input logic [W-1:0] v, input logic exp_ready);
    req_valid_i = 1'b1;
    req_div_i   = v;
    chk(tag, ready, exp_ready);
    if (exp_ready) exp_q.push_back(v);
    tick();
    req_valid_i = 1'b0;
  endtask

  // Sequence monitor: checks framing, collects the serial word and scores it on done.
  bit           in_seq = 1'b0;
  int           k      = 0;
  logic [W-1:0] word;

  always @(negedge clk) begin
    if (rst) begin
      in_seq = 1'b0;
    end else begin
      if (!in_seq && mode) begin
        in_seq = 1'b1;
        k      = 0;
        word   = '0;
        chk("seq_expected", exp_q.size() != 0, 1);
      end
      if (in_seq) begin
        chk("seq_busy", busy, 1);
        if (k < PRE) begin
          chk("pre_mode", mode, 1);
          chk("pre_bit", ser, 0);
        end else if (k < PRE + W) begin
          chk("shift_mode", mode, 1);
          word[k-PRE] = ser;
        end else begin
          chk("post_mode", mode, 0);
          chk("post_bit", ser, 0);
          if (k == PRE + W && exp_q.size() > 0) chk("cur_div_first_post", cur_div, exp_q[0]);
        end
        if (k == PRE + W + POST - 1) begin
          chk("done_last_post", done, 1);
          if (exp_q.size() > 0) begin
            chk("serial_word", word, exp_q[0]);
            void'(exp_q.pop_front());
          end
          in_seq = 1'b0;
        end else begin
          chk("no_early_done", done, 0);
        end
        k++;
      end
    end
  end

  initial begin
    int n;
    int done_at;

    rst         = 1'b1;
    req_valid_i = 1'b0;
    req_div_i   = '0;
    repeat (3) tick();
    chk("rst_mode", mode, 0);
    chk("rst_bit", ser, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_cur_div", cur_div, 0);

    // Automatic default load after reset release.
    exp_q.push_back(DEF);
    rst = 1'b0;
    chk("boot_ready_low", ready, 0);
    tick();
    chk("boot_mode", mode, 1);
    chk("boot_ready", ready, 1);
    wait_done("boot_load_time", 1, 36);
    tick();
    chk("boot_idle", busy, 0);
    chk("boot_cur_div", cur_div, DEF);

    // Single request from idle.
    send("idle_ready", 32'h0000_000A, 1'b1);
    chk("accept_to_pre", mode, 1);
    wait_done("a_load_time", 1, 36);
    tick();
    chk("a_idle", busy, 0);
    chk("a_cur_div", cur_div, 32'd10);

    // Pending slot and back-to-back sequences.
    send("direct_ready", 32'h1234_5678, 1'b1);
    send("busy_ready", 32'h8765_4321, 1'b1);
    chk("pend_full_ready", ready, 0);
    req_valid_i = 1'b1;
    req_div_i   = 32'h0F0F_F0F0;
    n           = 0;
    done_at     = -1;
    while (!ready && n < 100) begin
      if (done) done_at = n;
      tick();
      n++;
    end
    chk("first_done_cycle", done_at, 34);
    chk("held_accept_cycle", n, 35);
    chk("no_idle_gap_mode", mode, 1);
    chk("no_idle_gap_busy", busy, 1);
    exp_q.push_back(32'h0F0F_F0F0);
    tick();
    req_valid_i = 1'b0;

    // Request on the last postamble cycle with the slot full.
    wait_done("b_done", 0, 34);
    req_valid_i = 1'b1;
    req_div_i   = 32'hDEAD_BEEF;
    chk("last_post_ready", ready, 0);
    tick();
    chk("after_last_post_ready", ready, 1);
    chk("c_pre_mode", mode, 1);
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    req_valid_i = 1'b0;
    wait_done("c_done", 0, 34);
    wait_done("d_done", 0, 36);
    tick();
    chk("d_idle", busy, 0);

    // All ones then all zeros.
    send("ones_ready", 32'hFFFF_FFFF, 1'b1);
    send("zeros_ready", 32'h0000_0000, 1'b1);
    wait_done("ones_done", 0, 34);
    wait_done("zeros_done", 0, 36);
    tick();
    chk("zeros_idle", busy, 0);
    chk("zeros_cur_div", cur_div, 0);

    // Reset in the middle of SHIFT, with a value waiting in the slot.
    send("abort_ready", 32'h5555_AAAA, 1'b1);
    send("abort_pend_ready", 32'h1357_9BDF, 1'b1);
    repeat (18) tick();
    chk("bit17_mode", mode, 1);
    chk("bit17_value", ser, 0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("abort_mode", mode, 0);
    chk("abort_done", done, 0);
    chk("abort_cur_div", cur_div, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready_low", ready, 0);
    exp_q.push_back(DEF);
    rst = 1'b0;
    wait_done("reload_time", 0, 36);
    tick();
    chk("pending_discarded", busy, 0);
    chk("reload_cur_div", cur_div, DEF);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
